// File: rtl/weight_fetch_arbiter.sv
// weight_fetch_arbiter: shares the single memory read port between the RDN and
// DNN weight loaders. Engines are granted round-robin. Each granted load reads
// BEATS consecutive 512-bit lines, one read outstanding at a time. Each line is
// returned to its engine as eight 64-bit weights.
module weight_fetch_arbiter #(
  parameter int RDN_BEATS = 8,
  parameter int DNN_BEATS = 16,
  parameter int CNT_W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdn_req,
  input  logic [31:0]  rdn_base_addr,
  input  logic         dnn_req,
  input  logic [31:0]  dnn_base_addr,
  output logic         mem_read_request_valid,
  output logic [31:0]  mem_address,
  input  logic         mem_addr_accepted,
  input  logic         mem_data_valid,
  input  logic [511:0] mem_read_data,
  output logic [63:0]  rdn_weights [7:0],
  output logic         rdn_weight_vld,
  output logic         rdn_done,
  output logic [63:0]  dnn_weights [7:0],
  output logic         dnn_weight_vld,
  output logic         dnn_done
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DONE} state_t;

  localparam logic ENG_RDN = 1'b0;
  localparam logic ENG_DNN = 1'b1;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [31:0]      addr_q, addr_d;
  logic             pick_dnn, last_beat;
  logic             cap_rdn_p0, cap_dnn_p0;
  logic             rdn_vld_p1, dnn_vld_p1;

  // Final beat of the current load depends on which engine owns it.
  function automatic logic is_last_beat(input logic eng, input logic [CNT_W-1:0] cnt);
    if (eng == ENG_DNN) return cnt == CNT_W'(DNN_BEATS - 1);
    return cnt == CNT_W'(RDN_BEATS - 1);
  endfunction

  // On a tie the engine that was not served last wins.
  assign pick_dnn   = (rdn_req && dnn_req) ? (last_grant_q == ENG_RDN) : dnn_req;
  assign last_beat  = is_last_beat(grant_q, beat_q);
  assign cap_rdn_p0 = (state_q == WAIT_DATA) && mem_data_valid && (grant_q == ENG_RDN);
  assign cap_dnn_p0 = (state_q == WAIT_DATA) && mem_data_valid && (grant_q == ENG_DNN);

  assign mem_read_request_valid = (state_q == REQ);
  assign mem_address            = addr_q;
  assign rdn_done               = (state_q == DONE) && (grant_q == ENG_RDN);
  assign dnn_done               = (state_q == DONE) && (grant_q == ENG_DNN);
  assign rdn_weight_vld         = rdn_vld_p1;
  assign dnn_weight_vld         = dnn_vld_p1;

  // Control state register; reset starts IDLE with DNN as last served.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= ENG_RDN;
      last_grant_q <= ENG_DNN;
      beat_q       <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
    end
  end

  // Next-state logic: grant, issue one line read, wait for it, repeat.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    case (state_q)
      IDLE: begin
        if (rdn_req || dnn_req) begin
          grant_d = pick_dnn;
          addr_d  = pick_dnn ? dnn_base_addr : rdn_base_addr;
          beat_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_addr_accepted) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (mem_data_valid) begin
          if (last_beat) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + CNT_W'(1);
            addr_d  = addr_q + 32'd1;
            state_d = REQ;
          end
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: capture the returned line into the owning engine's weights.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdn_vld_p1 <= 1'b0;
      dnn_vld_p1 <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rdn_weights[i] <= '0;
        dnn_weights[i] <= '0;
      end
    end else begin
      rdn_vld_p1 <= cap_rdn_p0;
      dnn_vld_p1 <= cap_dnn_p0;
      for (int i = 0; i < 8; i++) begin
        if (cap_rdn_p0) rdn_weights[i] <= mem_read_data[64*i +: 64];
        if (cap_dnn_p0) dnn_weights[i] <= mem_read_data[64*i +: 64];
      end
    end
  end

endmodule

// File: tb/tb_weight_fetch_arbiter.sv
// tb_weight_fetch_arbiter: table-driven load scenarios plus hand-written
// reset-abort and restart sequences. A memory model answers read requests,
// and a scoreboard tracks the expected request order and the returned lines.
module tb_weight_fetch_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdn_req, dnn_req;
  logic [31:0]  rdn_base_addr, dnn_base_addr;
  logic         mem_read_request_valid;
  logic [31:0]  mem_address;
  logic         mem_addr_accepted, mem_data_valid;
  logic [511:0] mem_read_data;
  logic [63:0]  rdn_weights [7:0];
  logic [63:0]  dnn_weights [7:0];
  logic         rdn_weight_vld, rdn_done, dnn_weight_vld, dnn_done;

  always #5 clk = ~clk;

  weight_fetch_arbiter #(.RDN_BEATS(8), .DNN_BEATS(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .rdn_req(rdn_req), .rdn_base_addr(rdn_base_addr),
    .dnn_req(dnn_req), .dnn_base_addr(dnn_base_addr),
    .mem_read_request_valid(mem_read_request_valid), .mem_address(mem_address),
    .mem_addr_accepted(mem_addr_accepted), .mem_data_valid(mem_data_valid),
    .mem_read_data(mem_read_data),
    .rdn_weights(rdn_weights), .rdn_weight_vld(rdn_weight_vld), .rdn_done(rdn_done),
    .dnn_weights(dnn_weights), .dnn_weight_vld(dnn_weight_vld), .dnn_done(dnn_done)
  );

  typedef struct { logic eng; logic [31:0] addr; logic last; } req_t;
  typedef struct { logic eng; logic [511:0] line; logic last; } rsp_t;
  typedef struct {
    string       name;
    bit          no_reset;
    int          rdn_loads, dnn_loads;
    logic [31:0] rbase, dbase;
    int          stall_beat, stall_len;
    bit          spur;
    int          pre_idle;
    logic [5:0]  exp_order;   // bit k: engine of load k, 1 = DNN
    int          n_loads;
  } scen_t;

  localparam int LIMIT = 3000;

  int checks = 0, failures = 0;
  req_t req_q[$];
  rsp_t rsp_q[$];
  int data_cnt, stall_beat, stall_len, stall_left, beat_in_load;
  int rdn_left, dnn_left, n_rdn_vld, n_dnn_vld, n_rdn_done, n_dnn_done;
  bit stall_done, spur_en, exp_vld;
  logic [31:0]  stall_addr;
  logic [511:0] pend_line;
  logic [63:0]  rdn_hold [8];
  logic [63:0]  dnn_hold [8];
  scen_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] line_of(input logic [31:0] a);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[64*i +: 64] = {a, 32'hC0DE_0000 | 32'(i)};
    return l;
  endfunction

  task automatic spurious();
    if (spur_en) begin
      mem_data_valid = 1'b1;
      for (int i = 0; i < 16; i++) mem_read_data[32*i +: 32] = $urandom;
    end
  endtask

  // One clock: monitor at the falling edge, then engine and memory models.
  task automatic tick();
    rsp_t r;
    req_t e;
    int bad_r, bad_d;
    @(negedge clk);
    if (rst) begin
      req_q.delete(); rsp_q.delete();
      data_cnt = 0; exp_vld = 0; stall_left = 0;
      for (int i = 0; i < 8; i++) begin rdn_hold[i] = '0; dnn_hold[i] = '0; end
    end
    check("vld_exclusive", 64'(rdn_weight_vld & dnn_weight_vld), 64'd0);
    check("done_exclusive", 64'(rdn_done & dnn_done), 64'd0);
    check("vld_timing", 64'(rdn_weight_vld | dnn_weight_vld), 64'(exp_vld));
    if (rdn_weight_vld || dnn_weight_vld) begin
      if (rsp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL vld_unexpected actual=rdn%0b_dnn%0b required=no_strobe", rdn_weight_vld, dnn_weight_vld);
      end else begin
        r = rsp_q.pop_front();
        check("vld_engine", 64'(dnn_weight_vld), 64'(r.eng));
        check("rdn_done_on_last", 64'(rdn_done), 64'(r.last & ~r.eng));
        check("dnn_done_on_last", 64'(dnn_done), 64'(r.last & r.eng));
        for (int i = 0; i < 8; i++) begin
          if (r.eng) dnn_hold[i] = r.line[64*i +: 64];
          else       rdn_hold[i] = r.line[64*i +: 64];
        end
      end
    end else begin
      check("done_without_vld", 64'(rdn_done | dnn_done), 64'd0);
    end
    bad_r = 0; bad_d = 0;
    for (int i = 0; i < 8; i++) begin
      if (rdn_weights[i] !== rdn_hold[i]) bad_r++;
      if (dnn_weights[i] !== dnn_hold[i]) bad_d++;
    end
    check("rdn_weights_lanes_wrong", 64'(bad_r), 64'd0);
    check("dnn_weights_lanes_wrong", 64'(bad_d), 64'd0);
    if (rdn_weight_vld) n_rdn_vld++;
    if (dnn_weight_vld) n_dnn_vld++;
    if (rdn_done) n_rdn_done++;
    if (dnn_done) n_dnn_done++;
    exp_vld = 0;
    // engines drop req on the edge at which they see their final done
    if (rdn_done && rdn_left > 0) begin rdn_left--; if (rdn_left == 0) rdn_req = 1'b0; end
    if (dnn_done && dnn_left > 0) begin dnn_left--; if (dnn_left == 0) dnn_req = 1'b0; end
    // memory model: accept, then return the line two cycles later
    mem_addr_accepted = 1'b0;
    mem_data_valid    = 1'b0;
    if (!rst) begin
      if (data_cnt > 0) begin
        data_cnt--;
        if (data_cnt == 0) begin
          mem_data_valid = 1'b1; mem_read_data = pend_line; exp_vld = 1;
        end
      end else if (stall_left > 0) begin
        check("stall_valid_held", 64'(mem_read_request_valid), 64'd1);
        check("stall_addr_stable", 64'(mem_address), 64'(stall_addr));
        stall_left--;
        spurious();
      end else if (mem_read_request_valid) begin
        if (!stall_done && beat_in_load == stall_beat) begin
          stall_done = 1; stall_left = stall_len - 1; stall_addr = mem_address;
          spurious();
        end else begin
          mem_addr_accepted = 1'b1;
          data_cnt = 2;
          if (req_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL req_unexpected actual=%h required=no_request", mem_address);
          end else begin
            e = req_q.pop_front();
            check("req_addr", 64'(mem_address), 64'(e.addr));
            pend_line = line_of(mem_address);
            rsp_q.push_back('{e.eng, pend_line, e.last});
            beat_in_load = e.last ? 0 : beat_in_load + 1;
          end
        end
      end else begin
        spurious();
      end
    end
  endtask

  task automatic push_load(input logic eng, input logic [31:0] base);
    int nb;
    nb = eng ? 16 : 8;
    for (int b = 0; b < nb; b++) req_q.push_back('{eng, base + 32'(b), b == nb - 1});
  endtask

  task automatic clear_stats();
    n_rdn_vld = 0; n_dnn_vld = 0; n_rdn_done = 0; n_dnn_done = 0;
    beat_in_load = 0; stall_done = 0; stall_left = 0; stall_beat = -1; stall_len = 0; spur_en = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdn_req = 1'b0; dnn_req = 1'b0; rdn_left = 0; dnn_left = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (guard < LIMIT && !(req_q.size() == 0 && rsp_q.size() == 0 && data_cnt == 0 && !rdn_req && !dnn_req)) begin
      tick(); guard++;
    end
    if (guard >= LIMIT) $display("FAIL %s_timeout actual=%0d cycles required=drained", name, guard);
    check("drain_in_time", 64'(guard < LIMIT), 64'd1);
  endtask

  task automatic run_scen(input scen_t s);
    int er, ed;
    logic first_eng;
    if (!s.no_reset) do_reset();
    clear_stats();
    stall_beat = s.stall_beat; stall_len = s.stall_len; spur_en = s.spur;
    rdn_base_addr = s.rbase; dnn_base_addr = s.dbase;
    er = 0; ed = 0;
    for (int k = 0; k < s.n_loads; k++) begin
      push_load(s.exp_order[k], s.exp_order[k] ? s.dbase : s.rbase);
      if (s.exp_order[k]) ed++; else er++;
    end
    repeat (s.pre_idle) tick();
    rdn_left = s.rdn_loads; dnn_left = s.dnn_loads;
    rdn_req = (rdn_left > 0); dnn_req = (dnn_left > 0);
    first_eng = s.exp_order[0];
    tick();
    check("req_latency_valid", 64'(mem_read_request_valid), 64'd1);
    check("req_first_addr", 64'(mem_address), 64'(first_eng ? s.dbase : s.rbase));
    drain(s.name);
    check("rdn_vld_count", 64'(n_rdn_vld), 64'(er * 8));
    check("dnn_vld_count", 64'(n_dnn_vld), 64'(ed * 16));
    check("rdn_done_count", 64'(n_rdn_done), 64'(er));
    check("dnn_done_count", 64'(n_dnn_done), 64'(ed));
    spur_en = 0;
    repeat (3) tick();
    check("idle_after_load", 64'(mem_read_request_valid), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    int nz;
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      if (rdn_weights[i] !== 64'd0) nz++;
      if (dnn_weights[i] !== 64'd0) nz++;
    end
    check({name, "_weights_nonzero"}, 64'(nz), 64'd0);
    check({name, "_req_valid"}, 64'(mem_read_request_valid), 64'd0);
    check({name, "_address"}, 64'(mem_address), 64'd0);
    check({name, "_vlds"}, 64'({rdn_weight_vld, dnn_weight_vld}), 64'd0);
    check({name, "_dones"}, 64'({rdn_done, dnn_done}), 64'd0);
  endtask

  initial begin
    int guard;
    rst = 1'b1; rdn_req = 1'b0; dnn_req = 1'b0;
    rdn_base_addr = '0; dnn_base_addr = '0;
    mem_addr_accepted = 1'b0; mem_data_valid = 1'b0; mem_read_data = '0;
    data_cnt = 0; exp_vld = 0; pend_line = '0; stall_addr = '0;
    for (int i = 0; i < 8; i++) begin rdn_hold[i] = '0; dnn_hold[i] = '0; end
    clear_stats();

    //            name          nores rdn dnn rbase          dbase          stall len spur pre order       n
    tbl[0] = '{"single",       1'b0, 1,  0,  32'h0000_0100, 32'h0000_0000, -1,   0,  1'b0, 0, 6'b000000, 1};
    tbl[1] = '{"last_grant",   1'b1, 1,  1,  32'h0000_0180, 32'h0000_3000, -1,   0,  1'b0, 0, 6'b000001, 2};
    tbl[2] = '{"contention",   1'b0, 1,  1,  32'h0000_0200, 32'h0000_4000, -1,   0,  1'b0, 0, 6'b000010, 2};
    tbl[3] = '{"fairness",     1'b0, 3,  3,  32'h0000_0300, 32'h0000_5000, -1,   0,  1'b0, 0, 6'b101010, 6};
    tbl[4] = '{"backpressure", 1'b0, 1,  0,  32'h0000_0400, 32'h0000_0000, 3,    5,  1'b0, 0, 6'b000000, 1};
    tbl[5] = '{"spur_wrap",    1'b0, 0,  1,  32'h0000_0000, 32'hFFFF_FFFE, 0,    3,  1'b1, 3, 6'b000001, 1};

    do_reset();
    check_all_zero("reset");

    for (int t = 0; t < 6; t++) run_scen(tbl[t]);

    // reset while beat 2 of an RDN load is waiting for data
    do_reset();
    clear_stats();
    rdn_base_addr = 32'h0000_0600;
    push_load(1'b0, 32'h0000_0600);
    rdn_left = 1; rdn_req = 1'b1;
    guard = 0;
    while (!(beat_in_load == 3 && data_cnt == 2) && guard < 200) begin tick(); guard++; end
    check("reach_beat2", 64'(guard < 200), 64'd1);
    tick();
    rst = 1'b1; rdn_req = 1'b0; rdn_left = 0;
    tick();
    check_all_zero("abort");
    rst = 1'b0;
    repeat (4) tick();
    check("abort_no_done", 64'(n_rdn_done), 64'd0);
    check("abort_beats_before", 64'(n_rdn_vld), 64'd2);

    // fresh request restarts at beat 0 from the base address
    clear_stats();
    push_load(1'b0, 32'h0000_0600);
    rdn_left = 1; rdn_req = 1'b1;
    tick();
    check("restart_addr", 64'(mem_address), 64'h600);
    drain("restart");
    check("restart_vld_count", 64'(n_rdn_vld), 64'd8);
    check("restart_done_count", 64'(n_rdn_done), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_fetch_arbiter.md
Name: weight_fetch_arbiter

Overview:
- Shares the single memory read port between the RDN and DNN weight loaders.
- Each engine raises a level request for a block of weight lines. The arbiter grants the engines round-robin, issues one 512-bit line read at a time from that engine's base address, and returns each line as eight 64-bit weights.
- It pulses the engine's done signal after the last line.
- It sits inside the control unit, between the engines' weight request/done handshake and the memory read request/response interface.

Parameters:
- RDN_BEATS, 8: 512-bit lines per RDN weight load (>=1).
- DNN_BEATS, 16: 512-bit lines per DNN weight load (>=1).
- CNT_W, 8: beat counter width; must hold max(RDN_BEATS, DNN_BEATS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdn_req  in  1  RDN weight request, level
- rdn_base_addr  in  32  RDN first line address, sampled at grant
- dnn_req  in  1  DNN weight request, level
- dnn_base_addr  in  32  DNN first line address, sampled at grant
- mem_read_request_valid  out  1  read request to memory
- mem_address  out  32  line address of the read
- mem_addr_accepted  in  1  memory accepted the request this cycle
- mem_data_valid  in  1  mem_read_data valid
- mem_read_data  in  512  returned line
- rdn_weights  out  8x64  unpacked [7:0]; weight i = line bits [64i+63:64i]
- rdn_weight_vld  out  1  one-cycle strobe, new rdn_weights
- rdn_done  out  1  one-cycle pulse, RDN load complete
- dnn_weights  out  8x64  as rdn_weights
- dnn_weight_vld  out  1  as rdn_weight_vld
- dnn_done  out  1  as rdn_done

Behaviour:
- Reset: all outputs are 0 and state is IDLE. Beat counter, address register and grant are 0. last_grant = DNN, so RDN wins the first tie. Reset mid-operation aborts the transfer; no done is issued.
- States: IDLE, REQ, WAIT_DATA, DONE.
- IDLE:
  - If any req is high, grant one engine. With a single requester, grant it. With both high, grant the engine that is not last_grant.
  - Latch the granted engine's base address into the address register and clear the beat counter. Next state is REQ.
- REQ:
  - mem_read_request_valid = 1 and mem_address = address register.
  - If mem_addr_accepted, go to WAIT_DATA next cycle; otherwise stay, holding the address stable.
- WAIT_DATA:
  - On mem_data_valid, capture mem_read_data into the granted engine's weights register. That engine's weight_vld is 1 in the next cycle.
  - If beat counter == BEATS-1 for the granted engine, go to DONE. Otherwise increment the counter, add 1 to the address (32-bit wrap at 0xFFFFFFFF to 0), and return to REQ.
- DONE:
  - Granted engine's done = 1 for exactly this cycle; it coincides with the last weight_vld. Update last_grant to the granted engine.
  - Unconditionally go to IDLE; req is not sampled in DONE.
- Requester rule: an engine deasserts req on the clock edge at which it sees done. Otherwise it is re-granted after one IDLE cycle if the other engine is not requesting.
- Latency, uncontended: req sampled in IDLE at cycle 0 → request valid at cycle 1. Data accepted at cycle k → weight_vld at k+1.
- One read outstanding at a time.
- mem_data_valid outside WAIT_DATA is ignored; no state or output change.
- A req dropping mid-transfer is ignored; the load completes and done still pulses.
- The non-granted engine's weights register holds its value. Weights registers hold the last line until that engine's next beat.
- rdn_weight_vld and dnn_weight_vld are never high together, nor are rdn_done and dnn_done.

Test Plan:
- Single load: rdn_req=1, base 0x100, RDN_BEATS=8, memory accepts in 1 cycle and returns data 2 cycles later. Required:
  - Addresses 0x100..0x107 in order.
  - 8 rdn_weight_vld pulses, weights[i] matching the line slices.
  - rdn_done on the 8th pulse; no dnn activity.
- Contention: rdn_req and dnn_req rise together after reset. Required:
  - RDN served first (8 beats, rdn_done), then DNN at its base (16 beats, dnn_done).
  - No interleaving of addresses.
- Fairness: both engines re-request immediately after each done for 3 rounds. Required: grant order RDN, DNN, RDN, DNN, RDN, DNN.
- Backpressure: mem_addr_accepted held low 5 cycles on beat 3. Required: mem_read_request_valid and mem_address stay stable all 5 cycles; the load completes normally.
- Spurious and wrap: mem_data_valid pulsed while in IDLE and REQ; separately, a dnn load with base 0xFFFFFFFE and DNN_BEATS=4. Required:
  - The spurious pulses cause no vld.
  - Addresses are 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Reset mid-load: rst=1 for 1 cycle during WAIT_DATA of beat 2. Required:
  - All outputs 0 the next cycle and no done.
  - A fresh rdn_req then restarts at beat 0 from the base address.
